// File: rtl/lca_pkg.sv
// Shared types and width helpers for the linear-correspondence engine.
package lca_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } lca_state_e;

    // Index width that never collapses to zero bits.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/lca_correspondence_engine_table.sv
// Relation table: NUM_SUBJ x NUM_OBJ property vectors, one write port and
// two combinational read ports. Out-of-range writes are dropped.
module lca_relation_table
    import lca_pkg::*;
#(
    parameter int NUM_SUBJ = 4,
    parameter int NUM_OBJ  = 4,
    parameter int NUM_PROP = 8,
    localparam int SW = idx_w(NUM_SUBJ),
    localparam int OW = idx_w(NUM_OBJ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [SW-1:0]       wr_subj,
    input  logic [OW-1:0]       wr_obj,
    input  logic [NUM_PROP-1:0] wr_data,
    input  logic [SW-1:0]       rd_subj_a,
    input  logic [OW-1:0]       rd_obj_a,
    output logic [NUM_PROP-1:0] rd_data_a,
    input  logic [SW-1:0]       rd_subj_b,
    input  logic [OW-1:0]       rd_obj_b,
    output logic [NUM_PROP-1:0] rd_data_b
);

    localparam int DEPTH = NUM_SUBJ * NUM_OBJ;
    localparam int AW    = idx_w(DEPTH);

    logic [NUM_PROP-1:0] mem_q [DEPTH];
    logic [NUM_PROP-1:0] mem_d [DEPTH];

    function automatic logic in_range(input logic [SW-1:0] s,
                                      input logic [OW-1:0] o);
        return (int'(s) < NUM_SUBJ) && (int'(o) < NUM_OBJ);
    endfunction

    function automatic logic [AW-1:0] addr(input logic [SW-1:0] s,
                                           input logic [OW-1:0] o);
        return AW'(int'(s) * NUM_OBJ + int'(o));
    endfunction

    always_comb begin
        mem_d = mem_q;
        if (wr_en && in_range(wr_subj, wr_obj)) begin
            mem_d[addr(wr_subj, wr_obj)] = wr_data;
        end
    end

    assign rd_data_a = in_range(rd_subj_a, rd_obj_a) ?
                       mem_q[addr(rd_subj_a, rd_obj_a)] : '0;
    assign rd_data_b = in_range(rd_subj_b, rd_obj_b) ?
                       mem_q[addr(rd_subj_b, rd_obj_b)] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/lca_correspondence_engine.sv
// Sequential correspondence engine: scans two table vectors one property per cycle.
// Optional LCA_PROP_MASK_EN adds a property mask register sampled at query accept.
module lca_correspondence_engine
    import lca_pkg::*;
#(
    parameter int NUM_SUBJ = 4,
    parameter int NUM_OBJ  = 4,
    parameter int NUM_PROP = 8,
    parameter int TOL      = 0,
    localparam int SW = idx_w(NUM_SUBJ),
    localparam int OW = idx_w(NUM_OBJ),
    localparam int CW = cnt_w(NUM_PROP)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [SW-1:0]       wr_subj,
    input  logic [OW-1:0]       wr_obj,
    input  logic [NUM_PROP-1:0] wr_data,
`ifdef LCA_PROP_MASK_EN
    input  logic                mask_wr_en,
    input  logic [NUM_PROP-1:0] mask_data,
`endif
    input  logic                q_valid,
    output logic                q_ready,
    input  logic [SW-1:0]       q_subj1,
    input  logic [OW-1:0]       q_obj1,
    input  logic [SW-1:0]       q_subj2,
    input  logic [OW-1:0]       q_obj2,
    output logic                r_valid,
    input  logic                r_ready,
    output logic                r_is_linear,
    output logic [CW-1:0]       r_match_cnt,
    output logic                r_err,
    output logic                busy
);

    localparam int KW = idx_w(NUM_PROP);

    logic [NUM_PROP-1:0] rd1, rd2, cur_mask;
    logic                q_bad, hit, miss;

    lca_state_e          state_q, state_d;
    logic [NUM_PROP-1:0] vec1_q, vec1_d, vec2_q, vec2_d;
    logic [NUM_PROP-1:0] msk_q, msk_d;
    logic [KW-1:0]       k_q, k_d;
    logic [CW-1:0]       match_q, match_d, mism_q, mism_d;
    logic                q_ready_q, q_ready_d, r_valid_q, r_valid_d;
    logic                busy_q, busy_d, r_lin_q, r_lin_d, r_err_q, r_err_d;
    logic [CW-1:0]       r_cnt_q, r_cnt_d;

    lca_relation_table #(
        .NUM_SUBJ (NUM_SUBJ),
        .NUM_OBJ  (NUM_OBJ),
        .NUM_PROP (NUM_PROP)
    ) u_table (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_subj   (wr_subj),
        .wr_obj    (wr_obj),
        .wr_data   (wr_data),
        .rd_subj_a (q_subj1),
        .rd_obj_a  (q_obj1),
        .rd_data_a (rd1),
        .rd_subj_b (q_subj2),
        .rd_obj_b  (q_obj2),
        .rd_data_b (rd2)
    );

`ifdef LCA_PROP_MASK_EN
    logic [NUM_PROP-1:0] mask_q, mask_d;

    assign mask_d   = mask_wr_en ? mask_data : mask_q;
    assign cur_mask = mask_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q <= '1;
        end else begin
            mask_q <= mask_d;
        end
    end
`else
    assign cur_mask = '1;
`endif

    assign q_bad = (int'(q_subj1) >= NUM_SUBJ) || (int'(q_obj1) >= NUM_OBJ) ||
                   (int'(q_subj2) >= NUM_SUBJ) || (int'(q_obj2) >= NUM_OBJ);

    // Property k lives in bit NUM_PROP-1-k; vectors shift left each scan cycle.
    assign hit  = msk_q[NUM_PROP-1] && (vec1_q[NUM_PROP-1] == vec2_q[NUM_PROP-1]);
    assign miss = msk_q[NUM_PROP-1] && (vec1_q[NUM_PROP-1] != vec2_q[NUM_PROP-1]);

    always_comb begin
        state_d = state_q;
        vec1_d  = vec1_q;
        vec2_d  = vec2_q;
        msk_d   = msk_q;
        k_d     = k_q;
        match_d = match_q;
        mism_d  = mism_q;
        r_lin_d = r_lin_q;
        r_err_d = r_err_q;
        r_cnt_d = r_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (q_valid && q_bad) begin
                    state_d = DONE;
                    r_err_d = 1'b1;
                    r_lin_d = 1'b0;
                    r_cnt_d = '0;
                end else if (q_valid) begin
                    state_d = SCAN;
                    vec1_d  = rd1;
                    vec2_d  = rd2;
                    msk_d   = cur_mask;
                    k_d     = '0;
                    match_d = '0;
                    mism_d  = '0;
                end
            end
            SCAN: begin
                match_d = match_q + CW'(hit);
                mism_d  = mism_q + CW'(miss);
                vec1_d  = vec1_q << 1;
                vec2_d  = vec2_q << 1;
                msk_d   = msk_q << 1;
                k_d     = k_q + 1'b1;
                if (k_q == KW'(NUM_PROP - 1) || int'(mism_d) == TOL + 1) begin
                    state_d = DONE;
                    r_err_d = 1'b0;
                    r_cnt_d = match_d;
                    r_lin_d = (int'(mism_d) <= TOL);
                end
            end
            DONE: begin
                if (r_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        q_ready_d = (state_d == IDLE);
        r_valid_d = (state_d == DONE);
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            vec1_q    <= '0;
            vec2_q    <= '0;
            msk_q     <= '0;
            k_q       <= '0;
            match_q   <= '0;
            mism_q    <= '0;
            q_ready_q <= 1'b1;
            r_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            r_lin_q   <= 1'b0;
            r_err_q   <= 1'b0;
            r_cnt_q   <= '0;
        end else begin
            state_q   <= state_d;
            vec1_q    <= vec1_d;
            vec2_q    <= vec2_d;
            msk_q     <= msk_d;
            k_q       <= k_d;
            match_q   <= match_d;
            mism_q    <= mism_d;
            q_ready_q <= q_ready_d;
            r_valid_q <= r_valid_d;
            busy_q    <= busy_d;
            r_lin_q   <= r_lin_d;
            r_err_q   <= r_err_d;
            r_cnt_q   <= r_cnt_d;
        end
    end

    assign q_ready     = q_ready_q;
    assign r_valid     = r_valid_q;
    assign busy        = busy_q;
    assign r_is_linear = r_lin_q;
    assign r_err       = r_err_q;
    assign r_match_cnt = r_cnt_q;

endmodule

// File: tb/tb_lca_correspondence_engine.sv
// Bench for lca_correspondence_engine: two instances (TOL=0 and TOL=1) share
// stimulus and are checked every cycle against a query-level model.
module tb_lca_correspondence_engine;

    localparam int NS = 5;
    localparam int NO = 4;
    localparam int NP = 8;
    localparam int SW = 3;
    localparam int OW = 2;
    localparam int CW = 4;

    typedef struct packed {
        bit lin;
        bit err;
        int cnt;
        int lat;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          wr_en   = 1'b0;
    logic [SW-1:0] wr_subj = '0;
    logic [OW-1:0] wr_obj  = '0;
    logic [NP-1:0] wr_data = '0;
    logic          q_valid = 1'b0;
    logic [SW-1:0] q_subj1 = '0, q_subj2 = '0;
    logic [OW-1:0] q_obj1  = '0, q_obj2  = '0;
    logic          r_ready = 1'b0;
`ifdef LCA_PROP_MASK_EN
    logic          mask_wr_en = 1'b0;
    logic [NP-1:0] mask_data  = '1;
`endif

    logic [1:0]         q_ready, r_valid, r_lin, r_err, busy;
    logic [1:0][CW-1:0] r_cnt;

    for (genvar t = 0; t < 2; t++) begin : g_dut
        lca_correspondence_engine #(
            .NUM_SUBJ (NS),
            .NUM_OBJ  (NO),
            .NUM_PROP (NP),
            .TOL      (t)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .wr_en       (wr_en),
            .wr_subj     (wr_subj),
            .wr_obj      (wr_obj),
            .wr_data     (wr_data),
`ifdef LCA_PROP_MASK_EN
            .mask_wr_en  (mask_wr_en),
            .mask_data   (mask_data),
`endif
            .q_valid     (q_valid),
            .q_ready     (q_ready[t]),
            .q_subj1     (q_subj1),
            .q_obj1      (q_obj1),
            .q_subj2     (q_subj2),
            .q_obj2      (q_obj2),
            .r_valid     (r_valid[t]),
            .r_ready     (r_ready),
            .r_is_linear (r_lin[t]),
            .r_match_cnt (r_cnt[t]),
            .r_err       (r_err[t]),
            .busy        (busy[t])
        );
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input int t, input int act, input int want);
        checks++;
        if (act != want) begin
            failures++;
            $display("FAIL %s dut%0d got=%0d want=%0d t=%0t", nm, t, act, want, $time);
        end
    endtask

    // Query-level model: table contents, mask, and per-DUT outstanding result.
    logic [NP-1:0] tbl [NS*NO];
    logic [NP-1:0] mdl_mask = '1;
    int            cyc = 0;
    bit   [1:0]    pend = '0;
    int            acc [2];
    res_t          er [2];

    function automatic res_t eval(input logic [SW-1:0] s1, input logic [OW-1:0] o1,
                                  input logic [SW-1:0] s2, input logic [OW-1:0] o2,
                                  input int tol);
        res_t r;
        int mm;
        logic [NP-1:0] a, b;
        r = '0;
        if (s1 >= NS || s2 >= NS || o1 >= NO || o2 >= NO) begin
            r.err = 1'b1;
            r.lat = 1;
            return r;
        end
        a = tbl[int'(s1) * NO + int'(o1)];
        b = tbl[int'(s2) * NO + int'(o2)];
        mm = 0;
        r.lat = NP + 1;
        for (int k = 0; k < NP; k++) begin
            if (mdl_mask[NP-1-k]) begin
                if (a[NP-1-k] == b[NP-1-k]) r.cnt++;
                else mm++;
            end
            if (mm == tol + 1) begin
                r.lat = k + 2;
                break;
            end
        end
        r.lin = (mm <= tol);
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc      <= 0;
            pend     <= '0;
            mdl_mask <= '1;
            for (int i = 0; i < NS*NO; i++) tbl[i] <= '0;
        end else begin
            cyc <= cyc + 1;
            for (int t = 0; t < 2; t++) begin
                if (pend[t]) begin
                    if (cyc >= acc[t] + er[t].lat && r_ready) pend[t] <= 1'b0;
                end else if (q_valid) begin
                    er[t]   <= eval(q_subj1, q_obj1, q_subj2, q_obj2, t);
                    acc[t]  <= cyc;
                    pend[t] <= 1'b1;
                end
            end
            if (wr_en && wr_subj < NS && wr_obj < NO)
                tbl[int'(wr_subj) * NO + int'(wr_obj)] <= wr_data;
`ifdef LCA_PROP_MASK_EN
            if (mask_wr_en) mdl_mask <= mask_data;
`endif
        end
    end

    always @(negedge clk) begin
        for (int t = 0; t < 2; t++) begin
            bit ev;
            ev = pend[t] && (cyc >= acc[t] + er[t].lat);
            chk("q_ready", t, int'(q_ready[t]), int'(!pend[t]));
            chk("busy", t, int'(busy[t]), int'(pend[t]));
            chk("r_valid", t, int'(r_valid[t]), int'(ev));
            if (ev && r_valid[t]) begin
                chk("r_err", t, int'(r_err[t]), int'(er[t].err));
                chk("r_is_linear", t, int'(r_lin[t]), int'(er[t].lin));
                chk("r_match_cnt", t, int'(r_cnt[t]), er[t].cnt);
            end
        end
    end

    int cap_lat [2];
    int cap_cnt [2];
    int cap_lin [2];
    int cap_err [2];

    task automatic write(input int s, input int o, input logic [NP-1:0] d);
        wr_en = 1'b1; wr_subj = SW'(s); wr_obj = OW'(o); wr_data = d;
        @(posedge clk); #2;
        wr_en = 1'b0;
    endtask

    task automatic query(input int s1, input int o1, input int s2, input int o2,
                         input int hold, input bit wr_acc, input bit wr_mid,
                         input int ws, input int wo, input logic [NP-1:0] wd);
        int n;
        bit [1:0] got;
        q_valid = 1'b1;
        q_subj1 = SW'(s1); q_obj1 = OW'(o1);
        q_subj2 = SW'(s2); q_obj2 = OW'(o2);
        if (wr_acc) begin
            wr_en = 1'b1; wr_subj = SW'(ws); wr_obj = OW'(wo); wr_data = wd;
        end
        @(posedge clk); #2;
        q_valid = 1'b0;
        wr_en   = 1'b0;
        n = 1;
        got = '0;
        cap_lat = '{-1, -1};
        while (got != 2'b11 && n < 40) begin
            if (wr_mid && n == 3) begin
                wr_en = 1'b1; wr_subj = SW'(ws); wr_obj = OW'(wo); wr_data = wd;
            end else begin
                wr_en = 1'b0;
            end
            @(negedge clk);
            for (int t = 0; t < 2; t++) begin
                if (r_valid[t] && !got[t]) begin
                    got[t]     = 1'b1;
                    cap_lat[t] = n;
                    cap_cnt[t] = int'(r_cnt[t]);
                    cap_lin[t] = int'(r_lin[t]);
                    cap_err[t] = int'(r_err[t]);
                end
            end
            if (got != 2'b11) begin
                @(posedge clk); #2;
                n++;
            end
        end
        wr_en = 1'b0;
        if (got != 2'b11) begin
            checks++;
            failures++;
            $display("FAIL result_timeout got=%b want=11", got);
        end
        repeat (hold + 1) @(posedge clk);
        #2;
        if (hold > 0) begin
            for (int t = 0; t < 2; t++) begin
                chk("hold_valid", t, int'(r_valid[t]), 1);
                chk("hold_cnt", t, int'(r_cnt[t]), cap_cnt[t]);
            end
        end
        r_ready = 1'b1;
        @(posedge clk); #2;
        r_ready = 1'b0;
    endtask

    task automatic expect_res(input string nm, input int t, input int lat,
                              input int cnt, input int lin, input int err);
        chk({nm, "_lat"}, t, cap_lat[t], lat);
        chk({nm, "_cnt"}, t, cap_cnt[t], cnt);
        chk({nm, "_lin"}, t, cap_lin[t], lin);
        chk({nm, "_err"}, t, cap_err[t], err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        for (int t = 0; t < 2; t++) begin
            chk("rst_q_ready", t, int'(q_ready[t]), 1);
            chk("rst_r_valid", t, int'(r_valid[t]), 0);
            chk("rst_cnt", t, int'(r_cnt[t]), 0);
            chk("rst_lin", t, int'(r_lin[t]), 0);
            chk("rst_err", t, int'(r_err[t]), 0);
            chk("rst_busy", t, int'(busy[t]), 0);
        end
        @(posedge clk); #2;

        query(0, 0, 4, 3, 0, 0, 0, 0, 0, '0);
        for (int t = 0; t < 2; t++) expect_res("zero_tbl", t, 9, 8, 1, 0);

        write(0, 0, 8'hA5);
        write(1, 2, 8'hA5);
        query(0, 0, 1, 2, 0, 0, 0, 0, 0, '0);
        for (int t = 0; t < 2; t++) expect_res("a5_eq", t, 9, 8, 1, 0);

        write(0, 0, 8'hFF);
        write(3, 3, 8'h0F);
        query(0, 0, 3, 3, 0, 0, 0, 0, 0, '0);
        expect_res("early_t0", 0, 2, 0, 0, 0);
        expect_res("early_t1", 1, 3, 0, 0, 0);

        query(5, 0, 1, 2, 0, 0, 0, 0, 0, '0);
        for (int t = 0; t < 2; t++) expect_res("oor_subj1", t, 1, 0, 0, 1);
        query(1, 2, 7, 3, 0, 0, 0, 0, 0, '0);
        for (int t = 0; t < 2; t++) expect_res("oor_subj2", t, 1, 0, 0, 1);

        write(2, 1, 8'hA5);
        query(2, 1, 1, 2, 5, 1, 1, 1, 2, 8'h00);
        for (int t = 0; t < 2; t++) expect_res("rbw_hold", t, 9, 8, 1, 0);

        query(1, 2, 2, 1, 0, 0, 0, 0, 0, '0);
        expect_res("after_wr_t0", 0, 2, 0, 0, 0);
        expect_res("after_wr_t1", 1, 4, 1, 0, 0);

        write(7, 3, 8'hFF);
        query(4, 3, 1, 2, 0, 0, 0, 0, 0, '0);
        for (int t = 0; t < 2; t++) expect_res("oor_write", t, 9, 8, 1, 0);

`ifdef LCA_PROP_MASK_EN
        mask_wr_en = 1'b1; mask_data = 8'h0F;
        @(posedge clk); #2;
        mask_wr_en = 1'b0;
        write(0, 1, 8'hF0);
        write(0, 2, 8'h00);
        query(0, 1, 0, 2, 0, 0, 0, 0, 0, '0);
        for (int t = 0; t < 2; t++) expect_res("mask", t, 9, 4, 1, 0);
`endif

        q_valid = 1'b1;
        q_subj1 = 3'd0; q_obj1 = 2'd0; q_subj2 = 3'd1; q_obj2 = 2'd2;
        write(2, 1, 8'h5A);
        q_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        for (int t = 0; t < 2; t++) begin
            chk("midrst_valid", t, int'(r_valid[t]), 0);
            chk("midrst_ready", t, int'(q_ready[t]), 1);
            chk("midrst_busy", t, int'(busy[t]), 0);
        end
        @(posedge clk); #2 rst = 1'b0;
        repeat (12) @(posedge clk);
        #2;
        query(0, 1, 2, 1, 0, 0, 0, 0, 0, '0);
        for (int t = 0; t < 2; t++) expect_res("post_rst", t, 9, 8, 1, 0);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
